ode_start_sequencer: RTL

//  Multi-channel start sequencer for the shared Euler solver core. Latches start requests from
//  N_CH independent requesters and grants them round-robin, one at a time. Issues a 1-cycle

---
 rtl/ode_start_sequencer_pkg.sv | 15 +
 rtl/ode_start_sequencer_rr_pick.sv | 28 ++
 rtl/ode_start_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ode_start_sequencer_pkg.sv
// Shared types and helpers for the Euler solver start sequencer.
package ode_pkg;

    // Sequencer state: waiting for a request, or a run is in flight.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Channel-id width that never collapses to zero bits.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ode_start_sequencer_rr_pick.sv
// Rotate-priority picker: first pending channel after last_id, wrapping.
module ode_rr_pick #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic [N_CH-1:0] pend_eff,
    input  logic [ID_W-1:0] last_id,
    output logic [ID_W-1:0] sel,
    output logic            any
);

    int idx;

    // Scan last_id+1, last_id+2, ... mod N_CH; the first hit wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last_id) + k) % N_CH;
            if (!any && pend_eff[idx]) begin
                any = 1'b1;
                sel = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ode_start_sequencer.sv
// Round-robin start sequencer in front of the shared Euler solver core.
module ode_start_sequencer
    import ode_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_async_n,
    input  logic                      rst_sync,
    input  logic [N_CH-1:0]           req,
    input  logic                      final_done,
    output logic                      start,
    output logic [id_width(N_CH)-1:0] start_id,
    output logic                      busy,
    output logic [N_CH-1:0]           done_vec,
    output logic                      timeout_err,
    output logic [N_CH-1:0]           pend
);

    localparam int ID_W = id_width(N_CH);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic              start_q, start_d;
    logic [ID_W-1:0]   start_id_q, start_id_d;
    logic              busy_q, busy_d;
    logic [N_CH-1:0]   done_vec_q, done_vec_d;
    logic              timeout_err_q, timeout_err_d;

    logic [N_CH-1:0]   pend_eff;
    logic [ID_W-1:0]   sel;
    logic              any;
    logic              run_end;

    // A request counts in the same edge it arrives, so pending includes req.
    assign pend_eff = pend_q | req;

    ode_rr_pick #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_pick (
        .pend_eff (pend_eff),
        .last_id  (last_id_q),
        .sel      (sel),
        .any      (any)
    );

    // Next-state: run completion/timeout, then optional back-to-back grant.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_eff;
        timer_d       = timer_q;
        last_id_d     = last_id_q;
        start_d       = 1'b0;
        start_id_d    = start_id_q;
        busy_d        = busy_q;
        done_vec_d    = '0;
        timeout_err_d = 1'b0;
        run_end       = 1'b0;

        if (state_q == RUN) begin
            // Saturate so a run with the timeout disabled cannot wrap.
            if (timer_q != '1) timer_d = timer_q + 1'b1;
            // final_done in the start cycle is ignored; it also beats a timeout.
            if (final_done && !start_q) begin
                done_vec_d[start_id_q] = 1'b1;
                run_end                = 1'b1;
            end else if (TIMEOUT != 0 && timer_q == CNT_W'(TIMEOUT - 1)) begin
                timeout_err_d = 1'b1;
                run_end       = 1'b1;
            end
        end

        if (state_q == IDLE || run_end) begin
            if (any) begin
                start_d      = 1'b1;
                start_id_d   = sel;
                last_id_d    = sel;
                busy_d       = 1'b1;
                timer_d      = '0;
                pend_d[sel]  = 1'b0;
                state_d      = RUN;
            end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end

        // Synchronous clear overrides everything and matches the async reset state.
        if (rst_sync) begin
            state_d       = IDLE;
            pend_d        = '0;
            timer_d       = '0;
            last_id_d     = ID_W'(N_CH - 1);
            start_d       = 1'b0;
            start_id_d    = '0;
            busy_d        = 1'b0;
            done_vec_d    = '0;
            timeout_err_d = 1'b0;
        end
    end

    // State and registered outputs; last_id resets so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q       <= IDLE;
            pend_q        <= '0;
            timer_q       <= '0;
            last_id_q     <= ID_W'(N_CH - 1);
            start_q       <= 1'b0;
            start_id_q    <= '0;
            busy_q        <= 1'b0;
            done_vec_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            timer_q       <= timer_d;
            last_id_q     <= last_id_d;
            start_q       <= start_d;
            start_id_q    <= start_id_d;
            busy_q        <= busy_d;
            done_vec_q    <= done_vec_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign start       = start_q;
    assign start_id    = start_id_q;
    assign busy        = busy_q;
    assign done_vec    = done_vec_q;
    assign timeout_err = timeout_err_q;
    assign pend        = pend_q;

endmodule
